dda_run_ctrl: RTL and testbench

Run sequencer for the posit Van der Pol DDA core.
- Holds the run configuration: initial conditions, mu, dt, step count and decimation.
- Loads the initial conditions into the core's integrators, then steps the core a programmed number of times.
- Streams decimated (x, y) samples out over a valid/ready handshake. Downstream backpressure freezes integration.
- Sits between the chip I/O/config logic and the dda instance, and owns dda's en/rst pins.

---
 rtl/dda_run_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_dda_run_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dda_run_ctrl.sv
// dda_run_ctrl -- run sequencer for the posit Van der Pol DDA core.
// Holds the run configuration, loads the initial conditions into the core,
// steps it a programmed number of times and streams decimated (x, y) samples.
// Optional feature macro: DDA_RUN_CTRL_NAR_HALT_EN (halt the run on a NaR state).
//
// Sample handshake: a sample transfers on a rising clk edge where samp_valid
// and samp_ready are both high. Once samp_valid rises it stays high with
// samp_x/samp_y/samp_last stable until that transfer; only abort or reset
// retract it. Backpressure freezes the core (dda_en=0 while a sample waits).
module dda_run_ctrl #(
  parameter int N  = 16,
  parameter int ES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_addr,
  input  logic [N-1:0] cfg_wdata,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         dda_en,
  output logic         dda_rst,
  output logic [N-1:0] dda_icx,
  output logic [N-1:0] dda_icy,
  output logic [N-1:0] dda_mu,
  output logic [N-1:0] dda_dt,
  input  logic [N-1:0] dda_x,
  input  logic [N-1:0] dda_y,
  output logic         samp_valid,
  input  logic         samp_ready,
  output logic [N-1:0] samp_x,
  output logic [N-1:0] samp_y,
  output logic         samp_last,
  output logic [2:0]   dbg_state
);

  // ES only matters to the core; reject a width combination it cannot hold.
  if (ES > N - 2) begin : g_es_range
    $error("dda_run_ctrl: ES too large for N");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_next;
  logic         r_done;
  logic [N-1:0] r_icx;
  logic [N-1:0] r_icy;
  logic [N-1:0] r_mu;
  logic [N-1:0] r_dt;
  logic [N-1:0] r_steps;
  logic [N-1:0] r_decim;
  logic [N-1:0] r_steps_left;
  logic [N-1:0] r_dec_cnt;

  logic [N-1:0] w_decim_eff;
  logic         w_run_emit;
  logic         w_idle_like;
  logic         w_start_acc;
  logic         w_nar;
  logic         w_last;

  // Decimation of 0 behaves as 1; a RUN cycle ends its stretch on the
  // decimation boundary or on the final step so the last sample is the last step.
  always_comb begin
    w_decim_eff = (r_decim == '0) ? ONE : r_decim;
    w_run_emit  = (r_dec_cnt == w_decim_eff) || (r_steps_left == ONE);
    w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    w_start_acc = w_idle_like && start && !abort;
    w_last      = (r_steps_left == '0) || w_nar;
  end

`ifdef DDA_RUN_CTRL_NAR_HALT_EN
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
  logic r_err;

  // A NaR on either state output ends the run early.
  always_comb begin
    w_nar = (dda_x == NAR) || (dda_y == NAR);
  end

  // err is sticky from the halting sample until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if ((r_state == S_EMIT) && w_nar) begin
      r_err <= 1'b1;
    end
  end

  // The halting sample shows err while it is still being offered.
  always_comb begin
    err = r_err || ((r_state == S_EMIT) && w_nar);
  end
`else
  // Without the halt feature NaR values are ordinary samples.
  always_comb begin
    w_nar = 1'b0;
    err   = 1'b0;
  end
`endif

  // Next-state logic; abort outranks start and the sample handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_next = (r_steps == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_nar || w_run_emit) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (samp_ready) w_next = w_last ? S_DONE : S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // State register plus the one-cycle done pulse on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE) && (r_state != S_DONE);
    end
  end

  // Configuration registers, writable only while no run is in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_icx   <= '0;
      r_icy   <= '0;
      r_mu    <= '0;
      r_dt    <= '0;
      r_steps <= '0;
      r_decim <= '0;
    end else if (cfg_we && w_idle_like) begin
      case (cfg_addr)
        3'd0:    r_icx   <= cfg_wdata;
        3'd1:    r_icy   <= cfg_wdata;
        3'd2:    r_mu    <= cfg_wdata;
        3'd3:    r_dt    <= cfg_wdata;
        3'd4:    r_steps <= cfg_wdata;
        3'd5:    r_decim <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // Step and decimation counters; steps_left saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_steps_left <= '0;
      r_dec_cnt    <= '0;
    end else if (w_start_acc) begin
      r_steps_left <= r_steps;
      r_dec_cnt    <= ONE;
    end else if ((r_state == S_RUN) && !w_nar) begin
      if (r_steps_left != '0) r_steps_left <= r_steps_left - ONE;
      r_dec_cnt <= w_run_emit ? ONE : (r_dec_cnt + ONE);
    end
  end

  // Outputs decoded from the state; sample lanes read 0 outside EMIT.
  always_comb begin
    busy       = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_EMIT);
    done       = r_done;
    dda_rst    = (r_state == S_LOAD);
    dda_en     = (r_state == S_LOAD) || ((r_state == S_RUN) && !w_nar);
    dda_icx    = r_icx;
    dda_icy    = r_icy;
    dda_mu     = r_mu;
    dda_dt     = r_dt;
    samp_valid = (r_state == S_EMIT);
    samp_x     = '0;
    samp_y     = '0;
    samp_last  = 1'b0;
    if (r_state == S_EMIT) begin
      samp_x    = dda_x;
      samp_y    = dda_y;
      samp_last = w_last;
    end
    dbg_state  = r_state;
  end

endmodule

// File: tb/tb_dda_run_ctrl.sv
// tb_dda_run_ctrl -- self-checking bench for dda_run_ctrl.
// A simple integer stand-in for the DDA core is clocked by dda_en/dda_rst;
// expected samples come from a trajectory table built from the run rules.
module tb_dda_run_ctrl;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_addr = '0;
  logic [N-1:0] cfg_wdata = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         samp_ready = 1'b0;
  logic         busy, done, err, dda_en, dda_rst, samp_valid, samp_last;
  logic [N-1:0] dda_icx, dda_icy, dda_mu, dda_dt, dda_x, dda_y, samp_x, samp_y;
  logic [2:0]   dbg_state;

  int n_assert = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];
  logic        exp_err;
  logic [15:0] first_x;

  dda_run_ctrl #(.N(N), .ES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .dda_en(dda_en), .dda_rst(dda_rst), .dda_icx(dda_icx), .dda_icy(dda_icy),
    .dda_mu(dda_mu), .dda_dt(dda_dt), .dda_x(dda_x), .dda_y(dda_y),
    .samp_valid(samp_valid), .samp_ready(samp_ready), .samp_x(samp_x), .samp_y(samp_y),
    .samp_last(samp_last), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Stand-in core arithmetic (any deterministic map will do).
  function automatic logic [31:0] step_fn(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] mu, input logic [15:0] dt);
    logic [31:0] p;
    logic [15:0] nx, ny;
    p  = 32'(y) * 32'(dt);
    nx = x + p[29:14];
    ny = y - (x >> 3) + (mu >> 8);
    return {nx, ny};
  endfunction

  // Stand-in core: load on en&rst, step on en; x forced to NaR from step nar_at on.
  logic [15:0] cx = '0, cy = '0;
  int nsteps = 0;
  int nar_at = 0;
  always @(posedge clk) begin
    if (dda_en) begin
      if (dda_rst) begin
        cx <= dda_icx; cy <= dda_icy; nsteps <= 0;
      end else begin
        {cx, cy} <= step_fn(cx, cy, dda_mu, dda_dt);
        nsteps <= nsteps + 1;
      end
    end
  end
  assign dda_x = (nar_at != 0 && nsteps >= nar_at) ? 16'h8000 : cx;
  assign dda_y = cy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Reference: trajectory table, one sample per decim steps, last one at the final step.
  task automatic build_exp(input logic [15:0] icx, input logic [15:0] icy, input logic [15:0] mu,
                           input logic [15:0] dt, input logic [15:0] steps, input logic [15:0] decim,
                           input int nar);
    logic [15:0] tx[$];
    logic [15:0] ty[$];
    logic [31:0] nxt;
    int d, ns, s;
    exp_q.delete();
    exp_err = 1'b0;
    tx.push_back(icx); ty.push_back(icy);
    for (int i = 1; i <= int'(steps); i++) begin
      nxt = step_fn(tx[i-1], ty[i-1], mu, dt);
      tx.push_back(nxt[31:16]); ty.push_back(nxt[15:0]);
    end
    d  = (decim == 0) ? 1 : int'(decim);
    ns = (int'(steps) + d - 1) / d;
    for (int k = 1; k <= ns; k++) begin
      s = (k * d < int'(steps)) ? k * d : int'(steps);
`ifdef DDA_RUN_CTRL_NAR_HALT_EN
      if (nar != 0 && s >= nar) begin
        exp_q.push_back({1'b1, 16'h8000, ty[nar]});
        exp_err = 1'b1;
        break;
      end
`endif
      exp_q.push_back({(k == ns), ((nar != 0 && s >= nar) ? 16'h8000 : tx[s]), ty[s]});
    end
  endtask

  // One complete run: configure, start, consume samples, check timing and data.
  task automatic do_run(input logic [15:0] icx, input logic [15:0] icy, input logic [15:0] mu,
                        input logic [15:0] dt, input logic [15:0] steps, input logic [15:0] decim,
                        input int nar, input int stall, input bit rnd);
    int d, c, done_c, first_c, stall_left, exp_done, exp_first;
    bit hold, got_first;
    logic [15:0] hx, hy;
    logic [32:0] e;
    nar_at = nar;
    cfg_wr(3'd0, icx); cfg_wr(3'd1, icy); cfg_wr(3'd2, mu);
    cfg_wr(3'd3, dt);  cfg_wr(3'd4, steps); cfg_wr(3'd5, decim);
    chk("cfg_icx", dda_icx, icx); chk("cfg_icy", dda_icy, icy);
    chk("cfg_mu", dda_mu, mu);    chk("cfg_dt", dda_dt, dt);
    build_exp(icx, icy, mu, dt, steps, decim, nar);
    d = (decim == 0) ? 1 : int'(decim);
    exp_first = (steps == 0) ? -1 : (((int'(steps) < d) ? int'(steps) : d) + 2);
    exp_done  = (rnd || exp_err) ? -1 : 2 + int'(steps) + exp_q.size() + stall;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_c = -1; first_c = -1; hold = 0; got_first = 0; stall_left = stall;
    hx = '0; hy = '0;
    for (c = 1; c <= 600; c++) begin
      if (c == 1) begin
        chk("load_rst", dda_rst, 1); chk("load_en", dda_en, 1); chk("load_busy", busy, 1);
      end
      if (hold) begin
        chk("valid_held", samp_valid, 1); chk("x_stable", samp_x, hx); chk("y_stable", samp_y, hy);
      end
      if (samp_valid) begin
        if (first_c < 0) first_c = c;
        chk("emit_frozen", dda_en, 0);
        if (stall_left > 0) begin
          samp_ready = 1'b0; stall_left--;
        end else begin
          samp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (samp_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_sample", samp_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("samp_x", samp_x, e[31:16]); chk("samp_y", samp_y, e[15:0]);
            chk("samp_last", samp_last, e[32]);
            if (!got_first) begin first_x = samp_x; got_first = 1; end
          end
          hold = 0;
        end else begin
          hold = 1; hx = samp_x; hy = samp_y;
        end
      end else begin
        hold = 0;
        samp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (done) begin
        done_c = c;
        chk("done_busy", busy, 0); chk("done_err", err, exp_err);
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", done_c > 0, 1);
    if (exp_done >= 0) chk("done_cycle", done_c, exp_done);
    chk("first_valid", first_c, exp_first);
    chk("samples_left", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("err_hold", err, exp_err);
  endtask

  initial begin
    bit saw_done;
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_en", dda_en, 0); chk("rst_ddarst", dda_rst, 0); chk("rst_valid", samp_valid, 0);
    chk("rst_last", samp_last, 0); chk("rst_icx", dda_icx, 0); chk("rst_dt", dda_dt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run, decim 1
    do_run(16'h4000, 16'h0000, 16'h4000, 16'h2000, 16'd4, 16'd1, 0, 0, 0);
    chk("s1_first_x", first_x, 16'h4000);
    // Decimation 4 over 10 steps
    do_run(16'h4000, 16'h0100, 16'h4000, 16'h2000, 16'd10, 16'd4, 0, 0, 0);
    // Backpressure for 5 cycles on the first sample
    do_run(16'h4000, 16'h0000, 16'h4000, 16'h2000, 16'd4, 16'd1, 0, 5, 0);
    // Zero steps: load only, no samples
    do_run(16'h1234, 16'h0567, 16'h4000, 16'h2000, 16'd0, 16'd3, 0, 0, 0);
    chk("s4_x_loaded", dda_x, 16'h1234); chk("s4_y_loaded", dda_y, 16'h0567);
    // Decim 0 acts as 1
    do_run(16'h0800, 16'h0200, 16'h1000, 16'h1000, 16'd3, 16'd0, 0, 0, 0);
    // Randomized runs with random backpressure
    for (int r = 0; r < 5; r++) begin
      do_run(16'($urandom_range(0, 16'h3fff)), 16'($urandom_range(0, 16'h3fff)),
             16'($urandom_range(0, 16'hffff)), 16'($urandom_range(0, 16'hffff)),
             16'($urandom_range(1, 20)), 16'($urandom_range(0, 6)), 0, 0, 1);
    end
    // NaR appears after step 2 of 8
    do_run(16'h4000, 16'h0100, 16'h4000, 16'h2000, 16'd8, 16'd1, 2, 0, 0);
    nar_at = 0;

    // Abort in RUN on the 3rd step with a config write and start while busy
    cfg_wr(3'd2, 16'h1111); cfg_wr(3'd4, 16'd20); cfg_wr(3'd5, 16'd4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ab_busy_before", busy, 1); chk("ab_en_before", dda_en, 1);
    abort = 1'b1; start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 16'h1234;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
    chk("ab_busy", busy, 0); chk("ab_valid", samp_valid, 0); chk("ab_en", dda_en, 0);
    chk("ab_mu_kept", dda_mu, 16'h1111);
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    chk("ab_no_done", saw_done, 0);

    // Reset in the middle of EMIT
    cfg_wr(3'd4, 16'd4); cfg_wr(3'd5, 16'd1);
    samp_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !samp_valid; i++) @(negedge clk);
    chk("rm_emit_reached", samp_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_busy", busy, 0); chk("rm_valid", samp_valid, 0); chk("rm_en", dda_en, 0);
    chk("rm_x", samp_x, 0); chk("rm_last", samp_last, 0); chk("rm_done", done, 0);
    chk("rm_mu", dda_mu, 0); chk("rm_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
